// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: generates sequential PCs, issues SRAM-like fetch requests,
// and pairs returned instructions with their PCs, discarding responses made stale by a redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'hBFC00000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          PCQ_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] exc_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        ibuffer_full,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        inst_req_success,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        fetch_adel_o
);

  localparam int PTR_W = $clog2(PCQ_DEPTH);

  logic [31:0]      pc;
  logic [1:0]       outstanding;
  logic [1:0]       discard_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pc_q [PCQ_DEPTH];

  logic redirect;
  logic misaligned;
  logic resp;
  logic accept;
  logic forward;

  assign redirect   = flush | branch_flag;
  assign misaligned = (pc[1:0] != 2'b00);
  // A data_ok with nothing outstanding is a protocol violation and is ignored.
  assign resp       = inst_data_ok & (outstanding != 2'd0);
  assign forward    = resp & ~redirect & (discard_cnt == 2'd0);

  assign inst_req = resetn & ~redirect & ~ibuffer_full
                  & (outstanding < 2'(MAX_OUTSTANDING))
                  & ~misaligned & ~fetch_adel_o;
  assign accept           = inst_req & inst_addr_ok;
  assign inst_req_success = accept;
  assign inst_addr        = pc;
  assign pc_o             = pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc           <= RESET_PC;
      outstanding  <= 2'd0;
      discard_cnt  <= 2'd0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inst_o       <= 32'd0;
      inst_pc_o    <= 32'd0;
      inst_valid_o <= 1'b0;
      fetch_adel_o <= 1'b0;
    end else begin
      // accept is never set in a redirect cycle, so this also covers redirects.
      outstanding  <= outstanding + {1'b0, accept} - {1'b0, resp};
      inst_valid_o <= forward;
      if (forward) begin
        inst_o    <= inst_rdata;
        inst_pc_o <= pc_q[rd_ptr];
      end

      if (redirect) begin
        pc          <= flush ? exc_pc : branch_target;
        // Everything still in flight belongs to the old stream.
        discard_cnt <= outstanding - {1'b0, resp};
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        if (flush) fetch_adel_o <= 1'b0;
      end else begin
        if (accept) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (resp) begin
          if (discard_cnt != 2'd0) discard_cnt <= discard_cnt - 2'd1;
          else                     rd_ptr      <= rd_ptr + PTR_W'(1);
        end
        if (misaligned) fetch_adel_o <= 1'b1;
      end
    end
  end

  // NOTE: the PC queue storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) pc_q[wr_ptr] <= pc;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a bench-side memory model with stale tagging
// feeds a scoreboard of expected forwarded instructions.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] exc_pc = 32'd0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        ibuffer_full = 1'b0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_req_success;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        fetch_adel_o;

  inst_fetch_unit dut (
    .clk(clk), .resetn(resetn), .flush(flush), .exc_pc(exc_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .ibuffer_full(ibuffer_full), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .inst_req_success(inst_req_success), .pc_o(pc_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .fetch_adel_o(fetch_adel_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } fwd_t;

  pend_t pend[$];
  fwd_t  sb[$];
  bit    resp_en = 1'b0;
  int    n_assert = 0;
  int    n_fail = 0;
  logic        req_seen, succ_seen;
  logic [31:0] addr_seen, pco_seen;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, sample combinational outputs, update the
  // memory model, then compare registered outputs against the scoreboard.
  task automatic tick();
    pend_t e;
    fwd_t  f;
    bit    redirect;
    redirect = flush || branch_flag;
    if (!resetn) begin
      pend.delete();
      sb.delete();
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
    end else begin
      inst_data_ok = resp_en && (pend.size() > 0);
      inst_rdata   = inst_data_ok ? data_of(pend[0].addr) : 32'd0;
    end
    #1;
    req_seen  = inst_req;
    addr_seen = inst_addr;
    succ_seen = inst_req_success;
    pco_seen  = pc_o;
    if (inst_data_ok) begin
      e = pend.pop_front();
      if (!e.stale && !redirect) sb.push_back(fwd_t'{e.addr, data_of(e.addr)});
    end
    if (resetn && inst_req && inst_addr_ok) pend.push_back(pend_t'{inst_addr, redirect});
    if (redirect) foreach (pend[i]) pend[i].stale = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("inst_valid_o", {31'd0, inst_valid_o}, 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      f = sb.pop_front();
      check("inst_pc_o", inst_pc_o, f.pc);
      check("inst_o", inst_o, f.inst);
    end
  endtask

  initial begin
    @(negedge clk);

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check("rst inst_o", inst_o, 32'd0);
    check("rst inst_pc_o", inst_pc_o, 32'd0);
    check("rst fetch_adel_o", {31'd0, fetch_adel_o}, 32'd0);
    resetn = 1'b1;
    #1;
    check("rst inst_addr", inst_addr, 32'hBFC00000);

    // Free-running memory: one accept per cycle, sequential addresses
    inst_addr_ok = 1'b1;
    resp_en      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("run inst_req", {31'd0, req_seen}, 32'd1);
      check("run inst_req_success", {31'd0, succ_seen}, 32'd1);
      check("run inst_addr", addr_seen, 32'hBFC00000 + 32'(4 * i));
      check("run pc_o", pco_seen, 32'hBFC00000 + 32'(4 * i));
    end

    // Address not accepted: request held stable
    inst_addr_ok = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall inst_req", {31'd0, req_seen}, 32'd1);
      check("stall inst_addr", addr_seen, 32'hBFC00018);
      check("stall success", {31'd0, succ_seen}, 32'd0);
    end

    // Branch with two requests in flight: both responses discarded
    resetn = 1'b0;
    tick();
    resetn       = 1'b1;
    inst_addr_ok = 1'b1;
    resp_en      = 1'b0;
    tick();
    check("br addr0", addr_seen, 32'hBFC00000);
    tick();
    check("br addr1", addr_seen, 32'hBFC00004);
    tick();
    check("br max outstanding", {31'd0, req_seen}, 32'd0);
    branch_flag   = 1'b1;
    branch_target = 32'h80000100;
    tick();
    check("br no req in redirect", {31'd0, req_seen}, 32'd0);
    branch_flag  = 1'b0;
    inst_addr_ok = 1'b0;
    resp_en      = 1'b1;
    tick();
    tick();
    inst_addr_ok = 1'b1;
    tick();
    check("br new addr", addr_seen, 32'h80000100);
    check("br new success", {31'd0, succ_seen}, 32'd1);
    inst_addr_ok = 1'b0;
    tick();

    // Flush and branch together, with a response arriving in the redirect cycle
    inst_addr_ok = 1'b1;
    tick();
    flush         = 1'b1;
    branch_flag   = 1'b1;
    exc_pc        = 32'h80000180;
    branch_target = 32'h80000200;
    tick();
    check("fl no req in redirect", {31'd0, req_seen}, 32'd0);
    flush       = 1'b0;
    branch_flag = 1'b0;
    tick();
    check("fl priority addr", addr_seen, 32'h80000180);
    check("fl priority req", {31'd0, req_seen}, 32'd1);
    inst_addr_ok = 1'b0;
    tick();

    // Misaligned branch target raises fetch_adel_o until a flush
    inst_addr_ok  = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h80000102;
    tick();
    branch_flag = 1'b0;
    tick();
    check("adel no req", {31'd0, req_seen}, 32'd0);
    check("adel set", {31'd0, fetch_adel_o}, 32'd1);
    tick();
    check("adel held", {31'd0, fetch_adel_o}, 32'd1);
    branch_flag   = 1'b1;
    branch_target = 32'h80000300;
    tick();
    branch_flag = 1'b0;
    tick();
    check("adel survives branch", {31'd0, fetch_adel_o}, 32'd1);
    check("adel blocks req", {31'd0, req_seen}, 32'd0);
    flush  = 1'b1;
    exc_pc = 32'h80000180;
    tick();
    check("adel cleared by flush", {31'd0, fetch_adel_o}, 32'd0);
    flush = 1'b0;
    tick();
    check("adel resume addr", addr_seen, 32'h80000180);
    check("adel resume req", {31'd0, req_seen}, 32'd1);
    inst_addr_ok = 1'b0;
    tick();

    // Buffer full: no new requests, in-flight response still forwarded
    inst_addr_ok = 1'b1;
    resp_en      = 1'b0;
    tick();
    check("full pre addr", addr_seen, 32'h80000184);
    ibuffer_full = 1'b1;
    tick();
    check("full no req", {31'd0, req_seen}, 32'd0);
    resp_en = 1'b1;
    tick();
    check("full no req on resp", {31'd0, req_seen}, 32'd0);
    ibuffer_full = 1'b0;

    // PC wraps at the top of the address space
    branch_flag   = 1'b1;
    branch_target = 32'hFFFFFFFC;
    tick();
    branch_flag = 1'b0;
    tick();
    check("wrap addr top", addr_seen, 32'hFFFFFFFC);
    tick();
    check("wrap addr zero", addr_seen, 32'h00000000);
    inst_addr_ok = 1'b0;
    tick();
    tick();

    // Reset mid-transaction drops in-flight state
    inst_addr_ok = 1'b1;
    resp_en      = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    check("midrst inst_addr", inst_addr, 32'hBFC00000);
    inst_addr_ok = 1'b0;
    resp_en      = 1'b1;
    tick();
    check("midrst req", {31'd0, req_seen}, 32'd1);
    check("midrst addr", addr_seen, 32'hBFC00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
